sram_req_master: RTL and testbench
==================================

Name: sram_req_master

Overview:
- Initiator-side sequencer that drives the sram_core user interface: addr, data_in, enable, read_not_write, and collects data_out / ready.
- Accepts read/write commands from upstream logic (TT pin decoder or test logic) over a valid/ready handshake and buffers them in a small command FIFO.
- Issues commands one at a time to the SRAM core and returns read data over a second valid/ready response channel.

Parameters:
- ADDR_W, 10, SRAM word address width.
- DATA_W, 4, SRAM word width.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 15, cycles to wait for mem_ready before aborting; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  word address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  downstream accepts response.
- rsp_data  out  DATA_W  read data.
- rsp_err  out  1  response is a timeout abort. Tied 0 without the feature.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- mem_addr  out  ADDR_W  to sram_core addr.
- mem_wdata  out  DATA_W  to sram_core data_in.
- mem_enable  out  1  to sram_core enable.
- mem_rnw  out  1  to sram_core read_not_write; 1=read.
- mem_rdata  in  DATA_W  from sram_core data_out.
- mem_ready  in  1  from sram_core ready.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, FIFO empty, all outputs 0 except cmd_ready=1. mem_rnw=1. rsp_data=0.
- Command FIFO:
  - Push when cmd_valid&&cmd_ready. Pop only in IDLE.
  - cmd_ready = !full. Full at FIFO_DEPTH entries.
  - Pointers wrap modulo FIFO_DEPTH, with an extra MSB for full/empty.
  - Simultaneous push and pop when full: pop occurs, push refused because cmd_ready was 0 that cycle.
  - Push and pop in the same cycle when non-full: both happen, count unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
  - IDLE: if FIFO non-empty, pop the head into the op register (write, addr, wdata) and go to ISSUE next cycle.
  - ISSUE: mem_enable=1; mem_addr, mem_wdata and mem_rnw driven from the op register. Go to WAIT.
  - WAIT: mem_enable held 1 and mem_addr/mem_wdata/mem_rnw held stable.
    - On the cycle mem_ready=1: for a read, capture mem_rdata into rsp_data and go to RESP; for a write, go to GAP.
  - RESP: mem_enable=0, rsp_valid=1, rsp_data stable. On rsp_valid&&rsp_ready go to GAP. Stalls indefinitely while rsp_ready=0.
  - GAP: one cycle with mem_enable=0, so the core sees an enable edge per operation. Then go to IDLE.
- Writes produce no response.
- Minimum op spacing: IDLE→ISSUE→WAIT(≥1)→[RESP]→GAP→IDLE. Back-to-back writes with an immediate mem_ready take 4 cycles per op from pop to pop.
- mem_ready seen in ISSUE is ignored; it is sampled only in WAIT.
- mem_enable is registered and glitch-free.
- busy = (state!=IDLE) || !empty.
- Reset mid-operation: immediate abort, FIFO flushed, mem_enable drops asynchronously, no response emitted.

Optional Feature:
- Macro SRAM_REQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES without mem_ready, the FSM leaves WAIT.
  - For a read: go to RESP with rsp_err=1, rsp_data=0.
  - For a write: go to GAP and a sticky flag sets; rsp_err pulses with the next read response.
  - A late mem_ready after the abort is ignored.
- Undefined: no counter; WAIT waits forever; rsp_err constant 0.

Test Plan:
- Reset: rst=1 mid-WAIT → mem_enable=0 immediately; after release, cmd_ready=1, busy=0, rsp_valid=0.
- Write then read: push write addr=0x3A5 data=0xC, then read addr=0x3A5; model returns 0xC two cycles after enable → one response rsp_data=0xC; mem_enable low ≥1 cycle between the ops; mem_rnw=0 then 1.
- FIFO full: hold mem_ready=0 and push 5 reads with FIFO_DEPTH=4. Expected: 1 in the op register and 4 in the FIFO; cmd_ready=0 on the next push attempt; the 6th push is refused until the first completion.
- Response backpressure: read addr=0x001 returns 0x5 with rsp_ready=0 for 10 cycles → rsp_valid=1 and rsp_data=0x5 stable; no new mem_enable until rsp_ready=1.
- Address wrap: reads at 0x000 and 0x3FF return distinct model values 0x1 and 0xE in order.
- SRAM_REQ_TIMEOUT_EN: mem_ready never asserted on a read → rsp_valid with rsp_err=1, rsp_data=0 after TIMEOUT_CYCLES WAIT cycles; the next command proceeds normally.

Source files
------------

// File: rtl/sram_req_master.sv
// Command-FIFO sequencer driving the sram_core user interface, one op at a time.
// Optional WAIT timeout/abort compiled in with `define SRAM_REQ_TIMEOUT_EN.
module sram_req_master #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_enable,
  output logic              mem_rnw,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sram_req_master: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP} state_t;

  cmd_t        r_fifo [FIFO_DEPTH];
  logic [PW:0] r_wptr, r_rptr;
  cmd_t        r_op;
  state_t      r_state, w_next;
  logic        r_mem_en;
  logic [DATA_W-1:0] r_rsp_data;
  logic        w_empty, w_full, w_push, w_pop, w_tmo, w_to_resp;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push  = cmd_valid && !w_full;

  assign cmd_ready  = !w_full;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_data   = r_rsp_data;
  assign mem_enable = r_mem_en;
  assign mem_addr   = r_op.addr;
  assign mem_wdata  = r_op.wdata;
  assign mem_rnw    = !r_op.wr;
  assign w_to_resp  = (r_state == S_WAIT) && (w_next == S_RESP);

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[PW-1:0]] <= '{wr: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_empty) begin
                 w_pop  = 1'b1;
                 w_next = S_ISSUE;
               end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (mem_ready || w_tmo) w_next = r_op.wr ? S_GAP : S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_GAP;
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_op       <= '0;
      r_mem_en   <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_op   <= r_fifo[r_rptr[PW-1:0]];
      end
      // Registered from next state so the core sees a clean enable per op.
      r_mem_en <= (w_next == S_ISSUE) || (w_next == S_WAIT);
      if (w_to_resp) r_rsp_data <= mem_ready ? mem_rdata : '0;
    end
  end

`ifdef SRAM_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_sticky, r_rsp_err;

  assign w_tmo   = (r_state == S_WAIT) && !mem_ready && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_err = r_rsp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt    <= '0;
      r_sticky  <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_tcnt <= '0;
      else if (r_state == S_WAIT) r_tcnt <= r_tcnt + 1'b1;
      // An aborted write is reported on the next read response.
      if (w_tmo && r_op.wr) r_sticky <= 1'b1;
      else if (w_to_resp)   r_sticky <= 1'b0;
      if (w_to_resp) r_rsp_err <= w_tmo || r_sticky;
      else if (r_state == S_RESP && rsp_ready) r_rsp_err <= 1'b0;
    end
  end
`else
  assign w_tmo   = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_req_master.sv
// Directed bench for sram_req_master with a behavioural sram_core model.
module tb_sram_req_master;
  localparam int AW = 10, DW = 4, TMO = 15;

  logic clk = 1'b0, rst;
  logic cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_err, busy;
  logic [AW-1:0] cmd_addr, mem_addr;
  logic [DW-1:0] cmd_wdata, rsp_data, mem_wdata;
  logic mem_enable, mem_rnw;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_ready = 1'b0;

  always #5 clk = ~clk;

  sram_req_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_enable(mem_enable), .mem_rnw(mem_rnw),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;

  // SRAM model: ready pulse once enable has been high lat+1 edges.
  logic [DW-1:0] mdl [0:1023];
  logic ready_en;
  int lat, mcnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      mdl[0] <= 4'h1; mdl[1] <= 4'h5; mdl[10'h3FF] <= 4'hE;
      for (int k = 0; k < 6; k++) mdl[16+k] <= 4'(k + 6);
    end
    mcnt <= mem_enable ? mcnt + 1 : 0;
    if (ready_en && mem_enable && mcnt >= lat && !mem_ready) begin
      mem_ready <= 1'b1;
      mem_rdata <= mdl[mem_addr];
      if (!mem_rnw) mdl[mem_addr] <= mem_wdata;
    end else mem_ready <= 1'b0;
  end

  // Monitors: enable rises (cycle, rnw), enable-low run before a rise, response handshakes.
  logic prev_en = 1'b0;
  int low_run = 0, last_gap = 0;
  int rise_q[$];
  logic rnw_q[$], er_q[$];
  logic [DW-1:0] rd_q[$];
  always @(negedge clk) begin
    if (mem_enable && !prev_en) begin
      rise_q.push_back(cyc); rnw_q.push_back(mem_rnw); last_gap = low_run;
    end
    low_run = mem_enable ? 0 : low_run + 1;
    prev_en = mem_enable;
    if (rsp_valid && rsp_ready) begin rd_q.push_back(rsp_data); er_q.push_back(rsp_err); end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rise_q.delete(); rnw_q.delete(); rd_q.delete(); er_q.delete();
  endtask

  task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t = 0;
    while (!cmd_ready && t < 200) begin tick(); t++; end
    chk("push_ready_bound", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (busy && t < 300) begin tick(); t++; end
    chk(nm, int'(busy), 0);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          exp_rsp;
    logic [DW-1:0] exp_d;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, t, nr;
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; ready_en = 1'b1; lat = 1;
    tick(3);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_mem_enable", int'(mem_enable), 0);
    chk("rst_mem_rnw", int'(mem_rnw), 1);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    rst = 1'b0;
    tick();

    // Single ops, including the address extremes 0x000 and 0x3FF.
    tbl[0] = '{0, 10'h000, 4'h0, 1, 4'h1};
    tbl[1] = '{0, 10'h3FF, 4'h0, 1, 4'hE};
    tbl[2] = '{1, 10'h3A5, 4'hC, 0, 4'h0};
    tbl[3] = '{0, 10'h3A5, 4'h0, 1, 4'hC};
    tbl[4] = '{1, 10'h000, 4'h7, 0, 4'h0};
    tbl[5] = '{0, 10'h000, 4'h0, 1, 4'h7};
    tbl[6] = '{1, 10'h3FF, 4'h0, 0, 4'h0};
    tbl[7] = '{0, 10'h3FF, 4'h0, 1, 4'h0};
    tbl[8] = '{0, 10'h001, 4'h0, 1, 4'h5};
    for (int i = 0; i < 9; i++) begin
      clr();
      push(tbl[i].wr, tbl[i].a, tbl[i].d);
      wait_idle($sformatf("vec%0d_idle", i));
      chk($sformatf("vec%0d_nrsp", i), rd_q.size(), int'(tbl[i].exp_rsp));
      if (rd_q.size() > 0 && tbl[i].exp_rsp) chk($sformatf("vec%0d_data", i), int'(rd_q[0]), int'(tbl[i].exp_d));
      chk($sformatf("vec%0d_nops", i), rnw_q.size(), 1);
      if (rnw_q.size() > 0) chk($sformatf("vec%0d_rnw", i), int'(rnw_q[0]), int'(!tbl[i].wr));
    end

    // Write then read back-to-back through the FIFO.
    clr();
    push(1'b1, 10'h3A5, 4'hC);
    push(1'b0, 10'h3A5, 4'h0);
    wait_idle("wr_rd_idle");
    chk("wr_rd_nrsp", rd_q.size(), 1);
    if (rd_q.size() > 0) chk("wr_rd_data", int'(rd_q[0]), 'hC);
    chk("wr_rd_nops", rnw_q.size(), 2);
    if (rnw_q.size() == 2) begin
      chk("wr_rd_rnw0", int'(rnw_q[0]), 0);
      chk("wr_rd_rnw1", int'(rnw_q[1]), 1);
    end
    chk("wr_rd_gap", int'(last_gap >= 1), 1);

    // Back-to-back writes with immediate ready: 4 cycles pop to pop.
    lat = 0; clr();
    push(1'b1, 10'h100, 4'h1);
    push(1'b1, 10'h101, 4'h2);
    push(1'b1, 10'h102, 4'h3);
    wait_idle("wr3_idle");
    chk("wr3_nops", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      chk("wr3_spacing0", rise_q[1] - rise_q[0], 4);
      chk("wr3_spacing1", rise_q[2] - rise_q[1], 4);
    end
    chk("wr3_nrsp", rd_q.size(), 0);
    lat = 1;

    // FIFO full: one op stuck in WAIT plus four queued.
    ready_en = 1'b0; clr();
    for (int k = 0; k < 5; k++) push(1'b0, 10'(16 + k), 4'h0);
    chk("full_cmd_ready", int'(cmd_ready), 0);
    chk("full_busy", int'(busy), 1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h015;
    bad = 0;
    for (int k = 0; k < 5; k++) begin tick(); if (cmd_ready) bad++; end
    cmd_valid = 1'b0;
    chk("full_refused", bad, 0);
    ready_en = 1'b1;
    push(1'b0, 10'h015, 4'h0);
    chk("full_push_after_completion", int'(rd_q.size() >= 1), 1);
    wait_idle("full_idle");
    chk("full_nrsp", rd_q.size(), 6);
    if (rd_q.size() == 6)
      for (int k = 0; k < 6; k++) chk($sformatf("full_data%0d", k), int'(rd_q[k]), k + 6);

    // Response backpressure with a second read queued behind it.
    rsp_ready = 1'b0; clr();
    push(1'b0, 10'h001, 4'h0);
    push(1'b0, 10'h010, 4'h0);
    t = 0;
    while (!rsp_valid && t < 50) begin tick(); t++; end
    chk("bp_rsp_valid", int'(rsp_valid), 1);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!(rsp_valid && rsp_data == 4'h5 && !mem_enable)) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_no_new_enable", rise_q.size(), 1);
    rsp_ready = 1'b1;
    wait_idle("bp_idle");
    chk("bp_nrsp", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      chk("bp_data0", int'(rd_q[0]), 5);
      chk("bp_data1", int'(rd_q[1]), 6);
    end

    // Reset while the op sits in WAIT with another queued.
    ready_en = 1'b0; clr();
    push(1'b0, 10'h001, 4'h0);
    push(1'b0, 10'h002, 4'h0);
    t = 0;
    while (!mem_enable && t < 20) begin tick(); t++; end
    tick(2);
    chk("mid_wait_enable", int'(mem_enable), 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_enable", int'(mem_enable), 0);
    @(posedge clk); #1 rst = 1'b0;
    ready_en = 1'b1;
    tick();
    chk("rst2_cmd_ready", int'(cmd_ready), 1);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_rsp_valid", int'(rsp_valid), 0);
    tick(10);
    chk("rst2_no_rsp", rd_q.size(), 0);

`ifdef SRAM_REQ_TIMEOUT_EN
    ready_en = 1'b0; clr();
    push(1'b0, 10'h001, 4'h0);
    t = 0;
    while (!rsp_valid && t < 80) begin tick(); t++; end
    chk("tmo_rsp_valid", int'(rsp_valid), 1);
    chk("tmo_rsp_err", int'(rsp_err), 1);
    chk("tmo_rsp_data", int'(rsp_data), 0);
    if (rise_q.size() > 0) chk("tmo_wait_len", cyc - rise_q[0], TMO + 1);
    ready_en = 1'b1;
    wait_idle("tmo_idle");
    clr();
    push(1'b0, 10'h001, 4'h0);
    wait_idle("tmo_next_idle");
    nr = rd_q.size();
    chk("tmo_next_nrsp", nr, 1);
    if (nr == 1) begin
      chk("tmo_next_data", int'(rd_q[0]), 5);
      chk("tmo_next_err", int'(er_q[0]), 0);
    end
    // Aborted write flags the following read response.
    ready_en = 1'b0; clr();
    push(1'b1, 10'h020, 4'h9);
    wait_idle("tmo_wr_idle");
    ready_en = 1'b1;
    push(1'b0, 10'h001, 4'h0);
    wait_idle("tmo_sticky_idle");
    nr = rd_q.size();
    chk("tmo_sticky_nrsp", nr, 1);
    if (nr == 1) begin
      chk("tmo_sticky_err", int'(er_q[0]), 1);
      chk("tmo_sticky_data", int'(rd_q[0]), 5);
    end
`else
    nr = er_q.size();
    chk("no_tmo_err_low", int'(rsp_err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
